// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX; stalls the front of the pipe
// while busy. State table: IDLE idle/accept | DIVZERO zero divisor | RUN iterating | DONE result valid.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic                 annul_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   dvd, dvs, rem, quo;
    logic               qsign, rsign;
    logic [2*WIDTH-1:0] res;
    logic               live;

    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic               last, accept;

    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
        last    = (cnt == CW'(WIDTH - 1));
        op1_mag = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_mag = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        accept  = start_i && !annul_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (opdata2_i == '0) ? DIVZERO : RUN;
            DIVZERO: state_nxt = DONE;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (!start_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (annul_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // live gates stall_o so every output stays low until the first edge after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live  <= 1'b0;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            res   <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    res <= '0;
                    if (accept && opdata2_i != '0) begin
                        dvd   <= op1_mag;
                        dvs   <= op2_mag;
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= '0;
                        qsign <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        rsign <= signed_i & opdata1_i[WIDTH-1];
                    end
                end
                DIVZERO: res <= '0;
                RUN: begin
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CW'(1);
                    if (last)
                        res <= {(rsign ? -rem_nxt : rem_nxt), (qsign ? -quo_nxt : quo_nxt)};
                end
                default: ;
            endcase
            if (annul_i) res <= '0;
        end
    end

    assign ready_o  = (state == DONE);
    assign result_o = (state == DONE) ? res : '0;
    assign stall_o  = live & start_i & ~annul_i & (state != DONE);

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table of divides plus annul and async-reset sequences.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, annul_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;
    logic        ready_o, stall_o;

    int total = 0;
    int bad   = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                           input int lat);
        int n, stalls;
        bit done;
        start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
        #1;
        stalls = stall_o ? 1 : 0;
        n = 0; done = 0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                opdata1_i = ~a;
                opdata2_i = 32'h0;
                signed_i  = ~sgn;
            end
            if (ready_o) done = 1;
            else if (stall_o) stalls++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " stall cycles"}, 64'(stalls), 64'(lat));
        check({tag, " result"}, result_o, {r, q});
        check({tag, " stall in DONE"}, 64'(stall_o), 64'd0);
        start_i = 1'b0;
        tick();
        check({tag, " ready after drop"}, {63'd0, ready_o}, 64'd0);
        check({tag, " result after drop"}, result_o, 64'd0);
    endtask

    initial begin
        bit early;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD,   32'hFFFFFFFF,   33};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001,   33};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2};
        vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          2};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h00000000,   33};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'h00000000,   33};
        vecs[7]  = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC,   32'h00000001,   33};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E,   32'hFFFFFFFE,   33};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF,   32'h0000000F,   33};

        rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        #3;
        check("reset result", result_o, 64'd0);
        check("reset ready/stall", {62'd0, ready_o, stall_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++)
            run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].lat);

        // annul partway through RUN
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        tick();
        early = 0;
        repeat (10) begin
            tick();
            if (ready_o) early = 1;
        end
        check("annul no early ready", 64'(early), 64'd0);
        annul_i = 1'b1;
        #1;
        check("annul stall", 64'(stall_o), 64'd0);
        tick();
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        early = 0;
        repeat (40) begin
            tick();
            if (ready_o) early = 1;
        end
        check("annul no later ready", 64'(early), 64'd0);
        run_div("post-annul", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33);

        // asynchronous reset mid-RUN
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (6) tick();
        #2 rst = 1'b0;
        #1;
        check("async rst result", result_o, 64'd0);
        check("async rst ready/stall", {62'd0, ready_o, stall_o}, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        run_div("post-reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
- Its 64-bit result drives the aluout64E input of the EX/MEM pipeline register, which carries it to MEM for the HI/LO write.
- Stalls the front of the pipeline while a division is in flight.
- Supports cancellation when EX is flushed.

Parameters:
- WIDTH, 32, operand width in bits. The result is 2*WIDTH; only 32 is verified.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low; all state is cleared while rst==0.
- start_i  input  1  division requested by the instruction currently in EX; held high by the decoder while that instruction stays in EX.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i in IDLE.
- annul_i  input  1  cancel the in-flight or requested division (EX flush).
- opdata1_i  input  WIDTH  dividend; sampled in IDLE.
- opdata2_i  input  WIDTH  divisor; sampled in IDLE.
- result_o  output  2*WIDTH  {remainder, quotient}; remainder goes to HI, quotient to LO.
- ready_o  output  1  result_o is valid this cycle.
- stall_o  output  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE; result_o=0, ready_o=0, stall_o=0; counter and internal registers cleared.
  - Applies immediately in any state, including mid-RUN.
  - Outputs stay 0 until the first rising clk after rst returns to 1.
- States: IDLE, DIVZERO, RUN, DONE.
- IDLE:
  - start_i=1, annul_i=0, opdata2_i==0 -> DIVZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> RUN.
    - Latch the operand magnitudes: absolute values if signed_i, raw values otherwise.
    - Latch the quotient sign = op1[MSB]^op2[MSB] and the remainder sign = op1[MSB], both gated by signed_i.
    - Clear the partial remainder and set cnt=0.
  - Otherwise remain in IDLE.
- DIVZERO: next edge -> DONE with result 0. MIPS leaves HI/LO undefined; we define them as 0.
- RUN:
  - Each edge shifts the next dividend bit into the partial remainder.
  - Trial-subtracts the divisor (WIDTH+1-bit subtract).
  - Shifts a quotient bit of 1 if the result is non-negative, 0 otherwise, and keeps the difference if non-negative.
  - cnt increments; after the iteration with cnt==WIDTH-1, go -> DONE.
  - Sign correction is applied on entry to DONE: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
- DONE:
  - ready_o=1 and result_o holds the final value.
  - If start_i==0 -> IDLE, and ready_o and result_o return to 0.
  - If start_i stays 1, hold DONE. The stall is released, so the instruction advances and start_i drops on the next cycle.
- Annul: annul_i=1 in any state other than IDLE -> IDLE on the next edge.
  - No ready_o pulse, result_o=0.
  - annul_i has priority over every other transition.
- stall_o = start_i & ~annul_i & (state!=DONE), combinational.
  - Deasserts in the same cycle ready_o rises.
- Latency, counting the edge that samples start_i as edge 1:
  - Nonzero divisor: RUN covers edges 2..WIDTH+1 and DONE is entered at edge WIDTH+1. For WIDTH=32, ready_o is high after edge 33.
  - Zero divisor: ready_o is high after edge 2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF wraps, giving quotient 0x80000000 and remainder 0. No trap.
- Back-to-back divides: the second start is accepted only after a return to IDLE, i.e. at least one cycle with start_i=0, which the pipeline provides naturally.
- A start_i or operand change during RUN is ignored except through annul_i.

Test Plan:
- Unsigned 100/7, start_i held -> stall_o=1 for 33 cycles; after edge 33 ready_o=1 and result_o={32'd2, 32'd14}; start_i drop -> ready_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- 5/0 (either signedness) -> ready_o after edge 2, result_o=0, stall_o=0 in the DONE cycle.
- annul_i=1 at RUN iteration 10 -> IDLE next edge, no ready_o pulse, stall_o=0. A new 0xFFFFFFFF/0x10 DIVU then yields {0xF, 0x0FFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/0xFFFFFFFF -> {0, 1}.
- rst driven low asynchronously mid-RUN (between clock edges) -> result_o, ready_o and stall_o are 0 before the next clk edge. After release, a fresh 100/7 completes normally in 33 cycles.
